stall_controller: RTL
=====================

STALL_CONTROLLER -- requirements
Module: stall_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL clear immediately on rst_n low, independent of clk.
REQ-002 Parameter STALL_CYCLES, default 1, SHALL be the total freeze length in cycles per load-use stall; legal range is 1..3.
REQ-003 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 stall_req  input  1  load-use hazard request from hazard detection; combinational and valid the same cycle.
REQ-006 flush_req  input  1  branch/jump taken; squash the IF/ID instruction.
REQ-007 pc_write  output  1  PC write enable; 1 = advance.
REQ-008 ifid_write  output  1  IF/ID register write enable; 1 = load.
REQ-009 idex_bubble  output  1  1 = force ID/EX control fields (RegWrite, MemRead, MemWrite, Branch) to zero.
REQ-010 ifid_flush  output  1  1 = clear IF/ID to NOP on next edge.
REQ-011 stalling  output  1  1 while the FSM is in STALL.
REQ-012 stall_count  output  16  saturating count of stall bubbles inserted.

Function
REQ-013 FSM states SHALL be RUN and STALL, with a 2-bit remaining-cycles counter rem.
REQ-014 RUN, stall_req=0, flush_req=0: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0; stay RUN.
REQ-015 RUN, stall_req=1, flush_req=0: pc_write=0, ifid_write=0, idex_bubble=1 in the same cycle (zero latency).
REQ-016 In that case, if STALL_CYCLES=1, next state RUN; otherwise next state STALL with rem=STALL_CYCLES-1.
REQ-017 STALL: pc_write=0, ifid_write=0, idex_bubble=1, stalling=1; rem decrements each cycle; at rem=1 next state RUN.
REQ-018 stall_req SHALL be ignored while in STALL; it is re-evaluated in the first RUN cycle.
REQ-019 flush_req=1 in any state SHALL take priority: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; next state RUN; rem=0.
REQ-020 Simultaneous stall_req=1 and flush_req=1 SHALL be handled as flush only and not counted as a stall.
REQ-021 Outputs pc_write, ifid_write, idex_bubble and ifid_flush SHALL be combinational from state and inputs; stalling SHALL be decoded from state.
REQ-022 stall_count SHALL increment by 1 on every edge where idex_bubble=1 due to stall (not flush), saturating at 16'hFFFF.

Reset
REQ-023 While rst_n=0: state=RUN, rem=0, stall_count=0, stalling=0.
REQ-024 While rst_n=0, combinational outputs SHALL be pc_write=1, ifid_write=1, idex_bubble=0 and ifid_flush=0, regardless of inputs.
REQ-025 Reset asserted mid-STALL SHALL abandon the stall; the first cycle after release is RUN.

Configuration
REQ-026 With STALL_STATS_EN defined, the stall_count logic SHALL be present as specified.
REQ-027 Without STALL_STATS_EN, the stall_count port SHALL remain present and be tied to 16'h0000, with no counter flops.

Structure
REQ-028 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, STALL), STALL_MAX=3, REM_W=2 and STAT_W=16.
REQ-029 Sub-module sat_counter (width parameter, inc, saturating) SHALL implement stall_count and be instantiated only under STALL_STATS_EN.

Verification
REQ-030 STALL_CYCLES=1; stall_req pulse for 1 cycle -> exactly 1 cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_count=1.
REQ-031 STALL_CYCLES=3; stall_req pulse for 1 cycle -> 3 consecutive frozen cycles, stalling=1 on cycles 2-3; stall_count=3.
REQ-032 STALL_CYCLES=3; flush_req on 2nd frozen cycle -> that cycle ifid_flush=1, pc_write=1; next cycle RUN; stall_count=1.
REQ-033 stall_req=1 and flush_req=1 together -> flush outputs only; stall_count unchanged at 0.
REQ-034 rst_n low during STALL, released after 2 cycles -> pc_write=1 and stalling=0 immediately, stall_count=0.
REQ-035 Preload stall_count=16'hFFFE; 3 stalls -> 16'hFFFF held. Without STALL_STATS_EN, stall_count stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizing for the pipeline stall/flush controller.
// Imported by stall_controller and sat_counter.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int STALL_MAX = 3;
    localparam int REM_W     = 2;
    localparam int STAT_W    = 16;

    // Cycles still frozen after the first bubble of a load-use stall.
    function automatic logic [REM_W-1:0] rem_init(input int cycles);
        return REM_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
// Used for stall statistics (instantiated only with STALL_STATS_EN).
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = STAT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_full;

    assign w_full  = &r_count;
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && !w_full) begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/stall_controller.sv
// Load-use stall / branch flush controller for the IF/ID and ID/EX stages.
// Define STALL_STATS_EN to build the saturating stall_count statistic.
module stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_req,
    input  logic              flush_req,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              stalling,
    output logic [STAT_W-1:0] stall_count
);

    state_t           r_state;
    logic [REM_W-1:0] r_rem;

    state_t           w_next_state;
    logic [REM_W-1:0] w_next_rem;
    logic             w_pc_write;
    logic             w_ifid_write;
    logic             w_bubble;
    logic             w_flush;
    logic             w_stall_bub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_rem   <= '0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_rem   = r_rem;
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_bubble     = 1'b0;
        w_flush      = 1'b0;
        w_stall_bub  = 1'b0;
        if (!rst_n) begin
            w_next_state = RUN;
            w_next_rem   = '0;
        end else if (flush_req) begin
            // Flush wins over any stall, including one already in progress.
            w_flush      = 1'b1;
            w_bubble     = 1'b1;
            w_next_state = RUN;
            w_next_rem   = '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (stall_req) begin
                        w_pc_write   = 1'b0;
                        w_ifid_write = 1'b0;
                        w_bubble     = 1'b1;
                        w_stall_bub  = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            w_next_state = STALL;
                            w_next_rem   = rem_init(STALL_CYCLES);
                        end
                    end
                end
                STALL: begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_bubble     = 1'b1;
                    w_stall_bub  = 1'b1;
                    w_next_rem   = r_rem - REM_W'(1);
                    if (r_rem <= REM_W'(1)) begin
                        w_next_state = RUN;
                        w_next_rem   = '0;
                    end
                end
                default: begin
                    w_next_state = RUN;
                    w_next_rem   = '0;
                end
            endcase
        end
    end

    assign pc_write    = w_pc_write;
    assign ifid_write  = w_ifid_write;
    assign idex_bubble = w_bubble;
    assign ifid_flush  = w_flush;
    assign stalling    = (r_state == STALL);

`ifdef STALL_STATS_EN
    sat_counter #(
        .W(STAT_W)
    ) u_stat (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_stall_bub),
        .o_count(stall_count)
    );
`else
    logic w_unused_bub;
    assign w_unused_bub = w_stall_bub;
    assign stall_count  = '0;
`endif

endmodule
